// File: rtl/sub_m.sv
// sub_m: packed SIMD subtractor. Each word holds LANES signed LW-bit lanes,
// with lane 0 in the MSBs. Every non-reset edge registers the lane-wise
// difference m1 - m2 (two's-complement wrap-around) together with a single
// flag that is set when any lane overflowed. Lanes are fully independent:
// no borrow crosses a lane boundary.
module sub_m #(
    parameter int LANES = 5,
    parameter int LW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LANES*LW-1:0] m1,
    input  logic [LANES*LW-1:0] m2,
    output logic [LANES*LW-1:0] m_out,
    output logic                ovf
);

    localparam int W = LANES * LW;

    // Combinational lane results, registered below.
    logic [W-1:0]     diff;
    logic [LANES-1:0] lane_ovf;

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            logic [LW-1:0] a;
            logic [LW-1:0] b;
            logic [LW-1:0] r;

            assign a = m1[W-1-LW*k -: LW];
            assign b = m2[W-1-LW*k -: LW];
            // The truncated difference is the wrapped lane result.
            assign r = a - b;
            assign diff[W-1-LW*k -: LW] = r;
            // Overflow is only possible when the operand signs differ and the
            // result's sign no longer matches the minuend's.
            assign lane_ovf[k] = (a[LW-1] != b[LW-1]) && (r[LW-1] != a[LW-1]);
        end
    endgenerate

    // Result and flag are registered on the same edge so they stay coherent;
    // reset loads constants, so unknown inputs cannot reach the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_out <= '0;
            ovf   <= 1'b0;
        end else begin
            m_out <= diff;
            ovf   <= |lane_ovf;
        end
    end

endmodule

// File: tb/tb_sub_m.sv
// tb_sub_m: bench for the packed SIMD subtractor sub_m.
module tb_sub_m;

    localparam int W = 40;

    logic         clk;
    logic         rst;
    logic [W-1:0] m1;
    logic [W-1:0] m2;
    logic [W-1:0] m_out;
    logic         ovf;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[8];

    logic [W-1:0] exp_q[$];
    logic         exp_ovf_q[$];

    sub_m dut (
        .clk   (clk),
        .rst   (rst),
        .m1    (m1),
        .m2    (m2),
        .m_out (m_out),
        .ovf   (ovf)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: lane-wise difference evaluated as true integers,
    // overflow when the exact result leaves the int8 range.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic o);
        logic signed [7:0] sa;
        logic signed [7:0] sb;
        int d;
        r = '0;
        o = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sa = a[W-1-8*i -: 8];
            sb = b[W-1-8*i -: 8];
            d  = int'(sa) - int'(sb);
            r[W-1-8*i -: 8] = d[7:0];
            if (d > 127 || d < -128) o = 1'b1;
        end
    endfunction

    task automatic check(input string name, input logic [W-1:0] exp, input logic exp_o);
        n_checks++;
        if (m_out === exp && ovf === exp_o) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got m_out=%010h ovf=%0b, expected m_out=%010h ovf=%0b",
                     name, m_out, ovf, exp, exp_o);
        end
    endtask

    // Drive inputs mid-cycle, then sample 1 time unit after the next rising edge.
    task automatic step(input logic r, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        rst = r;
        m1  = a;
        m2  = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e;
        logic         eo;

        // Directed vectors with hand-computed results.
        vecs[0] = '{40'h0A141E2832, 40'h050F19232D, 40'h0505050505, 1'b0};
        vecs[1] = '{40'h0AEC1ED832, 40'hFB0FE723D3, 40'h0FDD37B55F, 1'b0};
        vecs[2] = '{40'h649C7F8032, 40'h1E1E01FF9C, 40'h467E7E8196, 1'b1};
        vecs[3] = '{40'h00807FFF05, 40'h80017F7F05, 40'h807F008000, 1'b1};
        vecs[4] = '{40'h0000000000, 40'h8000000000, 40'h8000000000, 1'b1};
        vecs[5] = '{40'h0080000000, 40'h0001000000, 40'h007F000000, 1'b1};
        vecs[6] = '{40'h000000FF00, 40'h0000007F00, 40'h0000008000, 1'b0};
        vecs[7] = '{40'h5AA5013CC3, 40'h5AA5013CC3, 40'h0000000000, 1'b0};

        rst = 1'b1;
        m1  = '0;
        m2  = '0;

        // Reset held for 5 cycles with arbitrary inputs.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, {$urandom, 8'($urandom)}, {$urandom, 8'($urandom)});
            check($sformatf("reset_%0d", i), 40'h0, 1'b0);
        end

        // First edge after release reflects the inputs present at that edge.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, vecs[i].a, vecs[i].b);
            check($sformatf("vec_%0d", i), vecs[i].exp, vecs[i].exp_ovf);
        end

        // Back-to-back stream with a single-cycle reset in the middle.
        for (int i = 0; i < 20; i++) begin
            a = {$urandom, 8'($urandom)};
            b = {$urandom, 8'($urandom)};
            if (i == 10) begin
                step(1'b1, a, b);
                exp_q.push_back('0);
                exp_ovf_q.push_back(1'b0);
            end else begin
                step(1'b0, a, b);
                model(a, b, e, eo);
                exp_q.push_back(e);
                exp_ovf_q.push_back(eo);
            end
            check($sformatf("stream_%0d", i), exp_q.pop_front(), exp_ovf_q.pop_front());
        end

        // Outputs hold while inputs are stable.
        step(1'b0, 40'h649C7F8032, 40'h1E1E01FF9C);
        step(1'b0, 40'h649C7F8032, 40'h1E1E01FF9C);
        check("hold", 40'h467E7E8196, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sub_m.md
Name: sub_m

Overview:
- Packed SIMD subtractor for the matrix coprocessor.
- Each operand is one 40-bit word holding five signed 8-bit lanes, e.g. one row of a 5x5 int8 matrix.
- Computes lane-wise m1 - m2 with two's-complement wrap-around and flags overflow in any lane.
- Fully registered, single pipeline stage; used by the matrix-subtract instruction path.

Parameters:
- LANES, 5, number of packed elements per word.
- LW, 8, width in bits of each signed lane; total word width = LANES*LW (40).

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  synchronous, active-high reset.
- m1  in  40  minuend; lane k at bits [39-8k : 32-8k], lane 0 in the MSBs; signed int8 per lane.
- m2  in  40  subtrahend; same packing as m1.
- m_out  out  40  registered lane-wise difference, same packing.
- ovf  out  1  registered; 1 when any lane of the registered result overflowed.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- On a rising clk edge with rst=1: m_out <= 0 and ovf <= 0. Inputs are ignored; X on inputs during reset must not propagate.
- On a rising clk edge with rst=0, for each lane k:
  - d_k = m1_k - m2_k, computed at LW+1 bits.
  - m_out_k <= d_k[LW-1:0] (wrap-around, no saturation).
- Lane overflow o_k = (sign(m1_k) != sign(m2_k)) AND (sign(result_k) != sign(m1_k)).
  - Equivalently, the 9-bit true difference is outside [-128, 127].
- ovf <= OR of o_k over all lanes, registered in the same edge as m_out so both are always coherent.
- Lanes are independent: no borrow propagates across lane boundaries.
- Latency: exactly 1 cycle from inputs to m_out/ovf. Throughput: 1 word per cycle. No handshake; inputs are sampled every non-reset edge.
- Outputs hold their value only while inputs are stable; there is no enable.
- Reset asserted mid-stream clears both outputs at the next edge. The first non-reset edge after deassertion produces the result of the inputs present at that edge.
- Boundary cases:
  - 0 - (-128) = 0x80, ovf=1.
  - -128 - 1 = 0x7F, ovf=1.
  - -1 - 127 = 0x80, ovf=0.
  - x - x = 0, ovf=0.
- The design must be purely synchronous. The only state is the 40-bit m_out register and the 1-bit ovf register.
- Parameter values other than the defaults must elaborate correctly (generate loop over lanes).

Test Plan:
- Reset: rst=1 for 5 cycles with any inputs -> m_out=0x0000000000, ovf=0. After release, the first edge reflects current inputs.
- Positive no overflow: m1=0x0A141E2832 [10,20,30,40,50], m2=0x050F19232D [5,15,25,35,45] -> next cycle m_out=0x0505050505, ovf=0.
- Mixed sign no overflow: m1=0x0AEC1ED832 [10,-20,30,-40,50], m2=0xFB0FE723D3 [-5,15,-25,35,-45] -> m_out=0x0FDD37B55F [15,-35,55,-75,95], ovf=0.
- Overflow mix: m1=0x649C7F8032 [100,-100,127,-128,50], m2=0x1E1E01FF9C [30,30,1,-1,-100] -> m_out=0x467E7E8196 [70,126,126,-127,-106], ovf=1 (lanes 1 and 4 wrap).
- Boundary lanes:
  - m1=0x00807FFF05, m2=0x80017F7F05 -> m_out=0x807F008000.
  - ovf=1: lanes 0 and 1 overflow; lane 2 = 0; lane 3 = -128 with no overflow; lane 4 = 0.
- Back-to-back and reset mid-stream:
  - Change inputs every cycle -> each result appears exactly one cycle later, with ovf aligned to its word.
  - Assert rst for one cycle mid-stream -> that output slot is 0/0, and the stream resumes on the next edge.
